// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus writes are queued in a byte FIFO and serialised LSB first on tx.
// Latency: a write into an empty, idle block makes tx fall 2 cycles later; each frame is 10*CLK_DIV cycles (11 with parity).
// Backpressure: none towards the bus; a write while full is silently dropped unless a pop happens in the same cycle.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit (8E1).

module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // A full FIFO still accepts a byte when a slot is freed in the same cycle.
    assign full   = (count == (AW+1)'(DEPTH));
    assign pop    = rd_rdy & (count != '0);
    assign push   = wr_vld & (~full | pop);
    assign rd_dat = mem[rd_ptr];

    // Storage array: written only on an accepted push, no reset needed.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_mmio #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          nReset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_d;
    logic        pop;
    logic        bit_end;
    logic [7:0]  fifo_dat;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .Clock  (Clock),
        .nReset (nReset),
        .wr_vld (wr_en),
        .wr_dat (wr_data),
        .rd_rdy (pop),
        .rd_dat (fifo_dat),
        .full   (full),
        .count  (fifo_count)
    );

    // Last cycle of the current bit period; the state advances here.
    assign bit_end = (baud_q == 16'(CLK_DIV - 1));
    assign busy    = (state_q != IDLE) | (fifo_count != '0);

    // Next-state, datapath and line value; tx is computed from the next state so the flop lines up with the state.
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_d = fifo_dat;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dat;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line high immediately.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
    localparam int CD = 4;
    localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       Clock = 1'b0;
    logic       nReset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [2:0] fifo_count;
    logic       busy;
    logic       tx;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    uart_tx_mmio #(.CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .fifo_count (fifo_count),
        .busy       (busy),
        .tx         (tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge of cycle cur0 of a frame (cycle 0 = first start-bit cycle).
    // Each bit is sampled on the last cycle of its period; bits already past are left unchecked.
    // Returns on the negedge of the last stop-bit cycle.
    task automatic frame(input logic [7:0] b, input int cur0, output logic [NB-1:0] got);
        logic [NB-1:0] exp;
        logic [NB-1:0] mask;
        int cur;
`ifdef UART_TX_PARITY_EN
        exp = {1'b1, ^b, b, 1'b0};
`else
        exp = {1'b1, b, 1'b0};
`endif
        got  = '0;
        mask = '0;
        cur  = cur0;
        for (int k = 0; k < NB; k++) begin
            if (CD*k + CD - 1 >= cur) begin
                repeat (CD*k + CD - 1 - cur) @(negedge Clock);
                cur     = CD*k + CD - 1;
                got[k]  = tx;
                mask[k] = 1'b1;
            end
        end
        chk($sformatf("frame_%02h", b), got & mask, exp & mask);
        chk("frame_last_cycle_busy", busy, 1);
    endtask

    // One idle cycle after the previous stop bit, then the next start bit.
    task automatic next_frame(input logic [7:0] b);
        logic [NB-1:0] got;
        @(negedge Clock);
        chk("gap_tx_high", tx, 1);
        @(negedge Clock);
        chk("next_start_low", tx, 0);
        frame(b, 0, got);
    endtask

    initial begin
        logic [NB-1:0] got;
        logic [7:0] b2 [4]   = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        logic [2:0] c2 [4]   = '{3'd1, 3'd1, 3'd2, 3'd3};
        logic       t2 [4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] c3 [6]   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic       f3 [6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       t3 [6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int lows;

        nReset  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge Clock);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", fifo_count, 0);
        nReset = 1'b1;
        @(negedge Clock);

        // Single 0x55 frame, latency and busy release.
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge Clock);
        wr_en = 1'b0;
        chk("t1_count", fifo_count, 1);
        chk("t1_tx_still_high", tx, 1);
        chk("t1_busy", busy, 1);
        @(negedge Clock);
        chk("t1_tx_falls", tx, 0);
        frame(8'h55, 0, got);
        @(negedge Clock);
        chk("t1_busy_drop", busy, 0);
        chk("t1_idle_tx", tx, 1);

        // Four back-to-back writes.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = b2[i];
            @(negedge Clock);
            chk($sformatf("t2_count_%0d", i), fifo_count, c2[i]);
            chk($sformatf("t2_tx_%0d", i), tx, t2[i]);
        end
        wr_en = 1'b0;
        frame(8'hA5, 2, got);
        next_frame(8'h3C);
        next_frame(8'hFF);
        next_frame(8'h00);
        @(negedge Clock);
        chk("t2_done_busy", busy, 0);
        chk("t2_done_count", fifo_count, 0);

        // Six writes in six cycles: fifth fills, sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            @(negedge Clock);
            chk($sformatf("t3_count_%0d", i), fifo_count, c3[i]);
            chk($sformatf("t3_full_%0d", i), full, f3[i]);
            chk($sformatf("t3_tx_%0d", i), tx, t3[i]);
        end
        wr_en = 1'b0;
        frame(8'h10, 4, got);
        next_frame(8'h11);
        next_frame(8'h12);
        next_frame(8'h13);
        next_frame(8'h14);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (tx !== 1'b1) lows++;
        end
        chk("t3_no_sixth_frame", lows, 0);
        chk("t3_idle_busy", busy, 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            @(negedge Clock);
        end
        wr_en = 1'b0;
        chk("t6_full_before", full, 1);
        frame(8'h20, 3, got);
        @(negedge Clock);
        chk("t6_idle_tx", tx, 1);
        chk("t6_idle_count", fifo_count, 4);
        wr_en = 1'b1; wr_data = 8'h25;
        @(negedge Clock);
        wr_en = 1'b0;
        chk("t6_count_kept", fifo_count, 4);
        chk("t6_full_kept", full, 1);
        chk("t6_start", tx, 0);
        frame(8'h21, 0, got);
        next_frame(8'h22);
        next_frame(8'h23);
        next_frame(8'h24);
        next_frame(8'h25);
        @(negedge Clock);
        chk("t6_done_busy", busy, 0);

        // Reset during data bit 3 of 0x81 with a second byte queued.
        wr_en = 1'b1; wr_data = 8'h81;
        @(negedge Clock);
        wr_data = 8'h42;
        @(negedge Clock);
        wr_en = 1'b0;
        repeat (17) @(negedge Clock);
        chk("t4_bit3_low", tx, 0);
        chk("t4_count_before", fifo_count, 1);
        nReset = 1'b0;
        #1;
        chk("t4_tx_async", tx, 1);
        chk("t4_count_cleared", fifo_count, 0);
        chk("t4_busy_cleared", busy, 0);
        @(negedge Clock);
        nReset = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (tx !== 1'b1) lows++;
        end
        chk("t4_no_frames", lows, 0);
        chk("t4_busy_after", busy, 0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; 44-cycle frames.
        wr_en = 1'b1; wr_data = 8'h07;
        @(negedge Clock);
        wr_en = 1'b0;
        @(negedge Clock);
        chk("t5_start_07", tx, 0);
        frame(8'h07, 0, got);
        chk("t5_parity_07", got[9], 1);
        @(negedge Clock);
        chk("t5_end_07", busy, 0);
        wr_en = 1'b1; wr_data = 8'h03;
        @(negedge Clock);
        wr_en = 1'b0;
        @(negedge Clock);
        chk("t5_start_03", tx, 0);
        frame(8'h03, 0, got);
        chk("t5_parity_03", got[9], 0);
        @(negedge Clock);
        chk("t5_end_03", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
